ttl_xor_accumulator: RTL and testbench
======================================

# ttl_xor_accumulator

Parametrised, clocked successor to the quad 2-input XOR model. It is a WIDTH-bit XOR datapath with an output register and three modes:
- parallel word XOR;
- running XOR accumulate, for parity and checksum;
- bit-serial XOR of two LSB-first streams, matching the Baby's serial word timing.

It sits between the store/accumulator data paths and the test/compare logic, and replaces ad-hoc banks of XOR gates followed by latches.

## Interface
Parameters:
- WIDTH, 32, word width in bits; minimum 2.
- PROPAGATION_DELAY, 22, ns delay from clk rising edge to any output change.

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- start  input  1  begin a serial XOR of WIDTH bits; sampled only in IDLE.
- load  input  1  parallel load: Y <= A ^ B.
- accumulate  input  1  parallel accumulate: Y <= Y ^ A.
- A  input  WIDTH  parallel operand A.
- B  input  WIDTH  parallel operand B.
- SA  input  1  serial stream A, LSB first.
- SB  input  1  serial stream B, LSB first.
- Y  output  WIDTH  result register.
- PARITY  output  1  XOR reduction of Y (1 = odd number of ones).
- ZERO  output  1  high when Y == 0; used as the equality flag after a compare.
- BUSY  output  1  high while a serial operation is in progress.
- DONE  output  1  one-cycle pulse when a serial result is complete.

## Operation
- State machine: IDLE, SHIFT, DONE.
- Bit counter: clog2(WIDTH) bits wide.
- Reset (reset_n low at a clk edge) forces:
  - state IDLE, counter 0;
  - Y = 0, so PARITY = 0 and ZERO = 1;
  - BUSY = 0, DONE = 0.
  - Reset overrides every other input, including mid-serial; the partial result is discarded.
- IDLE command priority is start > load > accumulate. One command executes per edge; lower-priority requests on the same edge are ignored.
  - start: Y <= 0, counter <= 0, state -> SHIFT.
  - load: Y <= A ^ B, state stays IDLE.
  - accumulate: Y <= Y ^ A, state stays IDLE. With accumulate held, consecutive edges chain.
  - No command: Y holds.
- SHIFT:
  - Each edge: Y <= {SA ^ SB, Y[WIDTH-1:1]}, i.e. shift right with the new bit entering at the MSB; counter increments.
  - On the edge where counter == WIDTH-1, the last bit is shifted in and state -> DONE.
  - After WIDTH shifts, bit i of Y is the XOR of the i-th stream bits (LSB arrives first).
  - start, load and accumulate are ignored in SHIFT.
- DONE:
  - Lasts exactly one cycle; Y holds; state -> IDLE.
  - Commands sampled on the DONE-exit edge are ignored. The first edge that accepts a command is the one after that.
- Output decoding:
  - BUSY = (state == SHIFT).
  - DONE = (state == DONE).
  - PARITY and ZERO are decoded from registered Y and carry the same PROPAGATION_DELAY.

## Timing
- Parallel latency: command sampled at edge n; Y, PARITY and ZERO are valid PROPAGATION_DELAY after edge n.
- Serial latency, with start sampled at edge s:
  - BUSY rises after edge s.
  - Stream bits are sampled at edges s+1 .. s+WIDTH.
  - BUSY falls and DONE rises after edge s+WIDTH.
  - DONE falls after edge s+WIDTH+1.
  - The next command is accepted at edge s+WIDTH+2 or later.
- Throughput: one serial word per WIDTH+2 cycles; one parallel operation per cycle.
- Partial results are visible on Y during SHIFT; only the value flagged by DONE is defined as the result.
- Counter wrap: the counter never exceeds WIDTH-1. A non-power-of-two WIDTH (e.g. 5) must still take exactly WIDTH shifts.
- Bench sampling: sample outputs at least 50 ns after a clk edge.

## Test plan
- Reset: assert reset_n = 0 for 2 edges with load = 1 and A = 8'hFF -> Y = 0, ZERO = 1, PARITY = 0, BUSY = 0, DONE = 0.
- Parallel load, WIDTH = 8:
  - A = 8'hA5, B = 8'h0F, load -> Y = 8'hAA, PARITY = 0, ZERO = 0.
  - Then A = 8'h5A, B = 8'h5A, load -> Y = 0, ZERO = 1.
- Accumulate chain, WIDTH = 8: load with A = 8'h01, B = 0; then accumulate with A = 8'h03, then A = 8'h80 -> Y = 8'h02, then 8'h82; PARITY = 0 at the end.
- Serial XOR, WIDTH = 8:
  - Streams SA = 8'hC3 and SB = 8'h3C, LSB first, after start -> BUSY high for exactly 8 cycles, DONE high for 1 cycle, Y = 8'hFF, PARITY = 0.
  - Repeat with equal streams 8'h96 -> Y = 0, ZERO = 1.
- Priority and ignore rules:
  - start, load and accumulate together in IDLE -> serial op begins and Y = 0 after the edge.
  - load pulsed mid-SHIFT, and start on the DONE-exit edge -> both ignored; the serial result is unchanged.
- Reset mid-operation, WIDTH = 5: reset_n low at the 3rd shift -> next cycle state IDLE, Y = 0, no DONE pulse. A following start with SA = 1, SB = 0 for 5 bits -> Y = 5'h1F after exactly 5 shifts.

Source files
------------

// File: rtl/ttl_xor_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : ttl_xor_accumulator
//  Purpose  : WIDTH-bit XOR datapath with result register. Supports parallel
//             word XOR (Y = A ^ B), running accumulate (Y = Y ^ A) and a
//             bit-serial XOR of two LSB-first streams.
//  Revision : 1.0  initial release
// ============================================================================
module ttl_xor_accumulator #(
    parameter int WIDTH             = 32,
    parameter int PROPAGATION_DELAY = 22
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             load,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SA,
    input  logic             SB,
    output logic [WIDTH-1:0] Y,
    output logic             PARITY,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Reject parameter values the datapath cannot represent.
    generate
        if (WIDTH < 2) begin : g_width_check
            $error("ttl_xor_accumulator: WIDTH must be at least 2");
        end
        if (PROPAGATION_DELAY < 0) begin : g_delay_check
            $error("ttl_xor_accumulator: PROPAGATION_DELAY must be non-negative");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_y;

    // Control FSM, bit counter and result register; reset wins over all inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // start > load > accumulate; only one command per edge.
                    if (start) begin
                        r_y     <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ST_SHIFT;
                    end else if (load) begin
                        r_y <= A ^ B;
                    end else if (accumulate) begin
                        r_y <= r_y ^ A;
                    end
                end
                c_ST_SHIFT: begin
                    // New bit enters at the MSB so the first (LSB) bit ends at bit 0.
                    r_y <= {SA ^ SB, r_y[WIDTH-1:1]};
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    // Single result cycle; commands seen here are dropped.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Y      = r_y;
    assign PARITY = ^r_y;
    assign ZERO   = (r_y == '0);
    assign BUSY   = (r_state == c_ST_SHIFT);
    assign DONE   = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ttl_xor_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ttl_xor_accumulator
//  Purpose  : Self-checking bench for ttl_xor_accumulator (WIDTH 8 and 5).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ttl_xor_accumulator;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    // WIDTH = 8 instance stimulus
    logic       reset_n = 1'b0, start = 1'b0, load = 1'b0, accumulate = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       sa = 1'b0, sb = 1'b0;
    logic [7:0] y;
    logic       parity, zero, busy, done;

    // WIDTH = 5 instance stimulus
    logic       reset_n5 = 1'b0, start5 = 1'b0;
    logic [4:0] a5 = '0, b5 = '0;
    logic       sa5 = 1'b0, sb5 = 1'b0;
    logic [4:0] y5;
    logic       parity5, zero5, busy5, done5;
    logic       load5 = 1'b0, acc5 = 1'b0;

    ttl_xor_accumulator #(.WIDTH(8), .PROPAGATION_DELAY(22)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .load(load),
        .accumulate(accumulate), .A(a), .B(b), .SA(sa), .SB(sb),
        .Y(y), .PARITY(parity), .ZERO(zero), .BUSY(busy), .DONE(done)
    );

    ttl_xor_accumulator #(.WIDTH(5), .PROPAGATION_DELAY(22)) u_dut5 (
        .clk(clk), .reset_n(reset_n5), .start(start5), .load(load5),
        .accumulate(acc5), .A(a5), .B(b5), .SA(sa5), .SB(sb5),
        .Y(y5), .PARITY(parity5), .ZERO(zero5), .BUSY(busy5), .DONE(done5)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of the WIDTH=8 instance: operating phase plus the two
    // stream words collected so far; Y is derived from them arithmetically.
    int         m_phase = 0;   // 0 idle, 1 serial in progress, 2 result cycle
    int         m_k     = 0;   // stream bits received
    logic [7:0] m_y     = '0;
    logic [7:0] m_sa    = '0;
    logic [7:0] m_sb    = '0;

    // One clock: advance the model with the inputs present at the edge, then
    // compare every output well after the edge.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            m_phase = 0;
            m_y     = '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_k = 0; m_sa = '0; m_sb = '0; m_y = '0;
            end else if (load) begin
                m_y = a ^ b;
            end else if (accumulate) begin
                m_y = m_y ^ a;
            end
        end else if (m_phase == 1) begin
            m_sa[m_k] = sa;
            m_sb[m_k] = sb;
            m_k++;
            // The first bit received has travelled to position 8-k.
            m_y = (m_sa ^ m_sb) << (8 - m_k);
            if (m_k == 8) m_phase = 2;
        end else begin
            m_phase = 0;
        end
        #60;
        check_val("y",      32'(y),      32'(m_y));
        check_val("parity", 32'(parity), 32'(^m_y));
        check_val("zero",   32'(zero),   32'(m_y == 8'h00));
        check_val("busy",   32'(busy),   32'(m_phase == 1));
        check_val("done",   32'(done),   32'(m_phase == 2));
    endtask

    // Serial XOR of two words on the WIDTH=8 instance; extra command noise
    // mid-shift and on the result-exit edge must be ignored.
    task automatic serial8(input logic [7:0] wa, input logic [7:0] wb,
                           input logic [7:0] exp_y, input string tag);
        int busy_cycles;
        logic [7:0] wa_v, wb_v;
        wa_v = wa; wb_v = wb;
        busy_cycles = 0;
        start = 1'b1; load = 1'b1; accumulate = 1'b1; a = 8'h77; b = 8'h11;
        step();
        check_val({tag, "_start_y0"}, 32'(y), 32'h0);
        start = 1'b0; load = 1'b0; accumulate = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cycles++;
            sa = wa_v[i]; sb = wb_v[i];
            load = (i == 3);
            step();
        end
        load = 1'b0;
        check_val({tag, "_busy_len"}, 32'(busy_cycles), 32'd8);
        check_val({tag, "_done"},     32'(done),        32'd1);
        check_val({tag, "_result"},   32'(y),           32'(exp_y));
        start = 1'b1; load = 1'b1; a = 8'h3C; b = 8'h00;
        step();
        start = 1'b0; load = 1'b0;
        check_val({tag, "_exit_y"},    32'(y),    32'(exp_y));
        check_val({tag, "_exit_busy"}, 32'(busy), 32'd0);
        step();
    endtask

    initial begin
        // Reset with a load request present; reset must win.
        load = 1'b1; a = 8'hFF;
        step(); step();
        check_val("rst_y", 32'(y), 32'h0);
        check_val("rst_zero", 32'(zero), 32'd1);
        reset_n = 1'b1;
        load = 1'b0;

        // Parallel load.
        a = 8'hA5; b = 8'h0F; load = 1'b1;
        step();
        check_val("load_aa", 32'(y), 32'hAA);
        a = 8'h5A; b = 8'h5A;
        step();
        check_val("load_eq_zero", 32'(zero), 32'd1);

        // Accumulate chain.
        a = 8'h01; b = 8'h00;
        step();
        load = 1'b0; accumulate = 1'b1; a = 8'h03;
        step();
        check_val("acc_02", 32'(y), 32'h02);
        a = 8'h80;
        step();
        check_val("acc_82", 32'(y), 32'h82);
        check_val("acc_parity", 32'(parity), 32'd0);
        accumulate = 1'b0;
        step();

        // Serial XOR.
        serial8(8'hC3, 8'h3C, 8'hFF, "ser_ff");
        serial8(8'h96, 8'h96, 8'h00, "ser_eq");
        check_val("ser_eq_zero", 32'(zero), 32'd1);

        // WIDTH=5: reset during the third shift, then a full 5-bit run.
        reset_n5 = 1'b1; start5 = 1'b1;
        step();
        start5 = 1'b0; sa5 = 1'b1; sb5 = 1'b0;
        step(); step();
        reset_n5 = 1'b0;
        step();
        check_val("w5_rst_y",    32'(y5),    32'h0);
        check_val("w5_rst_busy", 32'(busy5), 32'd0);
        check_val("w5_rst_done", 32'(done5), 32'd0);
        reset_n5 = 1'b1;
        step();
        check_val("w5_idle_done", 32'(done5), 32'd0);
        start5 = 1'b1;
        step();
        check_val("w5_busy_rise", 32'(busy5), 32'd1);
        start5 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i < 5) begin
                check_val("w5_busy_hold", 32'(busy5), 32'd1);
            end else begin
                check_val("w5_busy_fall", 32'(busy5), 32'd0);
                check_val("w5_done",      32'(done5), 32'd1);
                check_val("w5_result",    32'(y5),    32'h1F);
            end
        end
        step();
        check_val("w5_done_fall", 32'(done5), 32'd0);

        // Randomized traffic on the WIDTH=8 instance against the model.
        for (int i = 0; i < 400; i++) begin
            reset_n    = ($urandom_range(0, 49) != 0);
            start      = ($urandom_range(0, 7) == 0);
            load       = ($urandom_range(0, 2) == 0);
            accumulate = ($urandom_range(0, 1) == 0);
            a          = 8'($urandom);
            b          = 8'($urandom);
            sa         = 1'($urandom);
            sb         = 1'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
